uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver feeding the SRAM queue: deserialises 8N1 frames from the `rx` pin into bytes and presents them on a valid/ack handshake for the queue write side.
- Mirrors `uart_tx`: same `BAUD` parameter and same ack semantics.
- Adds metastability synchronisation, mid-bit sampling, and framing/overrun reporting.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division) must be >= 2; HALF = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  received byte, stable while valid=1.
- valid  output  1  byte available; held until consumed by ack.
- ack  input  1  consumer takes data_out on a clk edge where valid && ack.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while valid=1 and no ack.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; synchroniser flops = 1.
  - data_out = 0, valid = 0, frame_err = 0, overrun = 0, busy = 0; bit/clock counters = 0.
- Synchroniser: two flops on rx, giving rx_s. All decisions use rx_s only, so line edges reach the FSM 2 cycles late.
- FSM:
  - IDLE: rx_s==0 → START, load clock counter with HALF-1.
  - START: count down. At 0, sample rx_s:
    - 0 → DATA, bit index 0, counter CLKS_PER_BIT-1.
    - 1 → glitch, back to IDLE with no output.
  - DATA: count down. At 0, shift rx_s into bit[index], LSB first, and reload the counter. After index 7 → STOP.
  - STOP: count down. At 0, sample rx_s:
    - 1 → deliver, then IDLE.
    - 0 → frame_err pulse, byte discarded, → BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s==1, then IDLE. A held-low line (break) yields exactly one frame_err.
- Timing:
  - Sampling points are the centre of each bit ±1 clk.
  - Return to IDLE at the stop-bit centre, so a back-to-back start bit arriving half a bit later is caught.
- Deliver (registered, same edge as the stop sample):
  - valid=0, or valid=1 with ack=1 on that edge: data_out ← new byte, valid ← 1.
  - valid=1 and ack=0: new byte dropped, data_out/valid unchanged, overrun pulses for 1 cycle.
- Handshake:
  - valid falls on the edge after valid&&ack, unless a deliver coincides, in which case valid stays 1 with the new byte.
  - ack while valid=0 is ignored.
- Pulse outputs: frame_err and overrun are each exactly one cycle wide and never both in the same cycle.
- Latency: from the rx falling edge of the start bit to valid=1 is 2 + HALF + 9*CLKS_PER_BIT cycles (±1 for edge phase).
- Reset mid-frame: all of the above reset values apply immediately. After release, the receiver hunts for a fresh start bit and the partial frame is lost.

Test Plan:
1. CLK_HZ=100e6, BAUD=10e6 (10 clk/bit); drive 0x48 via uart_tx; ack held high → valid pulses 1 cycle with data_out=0x48 within 97±1 cycles of start edge; frame_err=overrun=0.
2. Send "Hello World!\n" back-to-back with ack=1 → 13 valid strobes carrying 0x48,0x65,0x6C,0x6C,0x6F,0x20,0x57,0x6F,0x72,0x6C,0x64,0x21,0x0A in order; no errors.
3. ack held 0, send 0x41 then 0x42 → data_out stays 0x41, valid stays 1, overrun pulses once at the second stop sample; then ack=1 for one cycle → valid drops next edge.
4. Frame 0x55 with stop bit forced low, rx then held low for 50 bit times → exactly one frame_err pulse, valid never rises, busy=1 until rx returns high; a following 0xA5 frame is received correctly.
5. 3-cycle low glitch on idle rx → busy rises, returns to IDLE after START sample, no valid/frame_err.
6. Assert rst during DATA bit 4 of a frame → all outputs 0 immediately; after release, the next complete frame (0x3C) is received correctly with no residue from the aborted one.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver for the SRAM queue write side.
//
// Deserialises frames arriving on `rx` into bytes. Each byte is held on
// data_out with valid=1 until the consumer takes it with ack. The line is
// double-flopped before use, and every bit is sampled near its centre by a
// down-counting clock divider. A stop bit sampled low is reported as
// frame_err. A byte that completes while the previous one is still unread
// is reported as overrun.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line bit rate; CLK_HZ/BAUD must be >= 2
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   data_out   received byte, stable while valid=1
//   valid      byte available; held until consumed by ack
//   ack        consumer takes data_out on an edge where valid && ack
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while valid=1 and no ack
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    // The counter only ever holds values up to CLKS_PER_BIT-1.
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_m;
    logic          rx_s;

    // Two-flop synchroniser. It resets to the idle level so that releasing
    // reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A consume retires the byte. A deliver on the same edge
            // overrides this below and keeps valid high with the new byte.
            if (valid && ack)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                        busy  <= 1'b1;
                    end
                end

                // Wait half a bit, then confirm that the line is still low.
                // A short low pulse is treated as a glitch.
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (!rx_s) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        cnt     <= CNT_FULL;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                // The line sends the LSB first. Each sample is shifted in at
                // the MSB end, so after 8 samples bit 0 sits in shreg[0].
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= CNT_FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end

                // Leave at the stop-bit centre. This leaves half a bit of
                // margin to catch a start bit that follows directly.
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rx_s) begin
                        if (!valid || ack) begin
                            data_out <= shreg;
                            valid    <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK_WAIT;
                    end
                end

                // Absorb a held-low line (break) so that it reports only one
                // frame_err instead of a stream of bogus frames.
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 10 clocks per bit.
//
// The line driver builds 8N1 frames bit by bit from the byte value. A monitor
// samples the DUT just before each rising edge. It records consumed bytes,
// valid cycles and error pulses. Expected bytes are queued as they are sent,
// and the two queues are compared.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLK_HZ(100_000_000), .BAUD(10_000_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ack       (ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 1 ns before each rising edge, when inputs and outputs
    // are both settled.
    logic [7:0] rxq[$];
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vcyc = 0, rise_cyc = 0;
    logic vprev = 1'b0;
    always @(negedge clk) begin
        #4;
        if (valid && ack) rxq.push_back(data_out);
        if (valid) vcyc++;
        if (valid && !vprev) rise_cyc = cyc;
        vprev = valid;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit time. The caller is at a falling edge and is left at one.
    task automatic hold(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    int start_cyc = 0;

    // abort_bit >= 0 asserts reset halfway through that data bit and abandons
    // the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int abort_bit);
        start_cyc = cyc;
        hold(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rx = b[i];
                repeat (HALF) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_valid",    32'(valid),     32'd0);
                check("rst_data",     32'(data_out),  32'd0);
                check("rst_busy",     32'(busy),      32'd0);
                check("rst_frame_err",32'(frame_err), 32'd0);
                check("rst_overrun",  32'(overrun),   32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                rx  = 1'b1;
                return;
            end
            hold(b[i]);
        end
        hold(stop_v);
    endtask

    logic [7:0] expq[$];
    int base;

    task automatic cmp_rx(input string tag);
        check({tag, "_count"}, 32'(rxq.size() - base), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            if (base + i < rxq.size())
                check({tag, "_byte"}, 32'(rxq[base + i]), 32'(expq[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] hello [13];
        logic [7:0] b;
        int fe0, ov0, v0, lat;

        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                  8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid",     32'(valid),     32'd0);
        check("reset_data",      32'(data_out),  32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1);

        // 1: single byte, ack held high
        ack = 1'b1;
        base = rxq.size(); expq.delete();
        v0 = vcyc; fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h48, 1'b1, -1);
        expq.push_back(8'h48);
        lat = rise_cyc - start_cyc;
        hold(1'b1);
        cmp_rx("single");
        check("single_valid_width", 32'(vcyc - v0), 32'd1);
        checks++;
        assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
            errors++;
            $error("FAIL latency: observed %0d expected %0d..%0d", lat, LAT - 1, LAT + 1);
        end
        check("single_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // 2: back-to-back string
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 13; i++) begin
            send_frame(hello[i], 1'b1, -1);
            expq.push_back(hello[i]);
        end
        hold(1'b1);
        cmp_rx("hello");
        check("hello_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // Randomised bytes with random idle gaps
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1);
            expq.push_back(b);
            repeat ($urandom_range(0, 2)) hold(1'b1);
        end
        hold(1'b1);
        cmp_rx("random");
        check("random_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // 3: overrun while unacknowledged
        ack = 1'b0;
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h41, 1'b1, -1);
        send_frame(8'h42, 1'b1, -1);
        hold(1'b1);
        #1;
        check("ovr_data",  32'(data_out),      32'h41);
        check("ovr_valid", 32'(valid),         32'd1);
        check("ovr_count", 32'(ov_cnt - ov0),  32'd1);
        check("ovr_fe",    32'(fe_cnt - fe0),  32'd0);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        check("ovr_valid_drop", 32'(valid), 32'd0);
        expq.push_back(8'h41);
        hold(1'b1);
        cmp_rx("ovr");

        // 4: bad stop bit followed by a long break
        ack = 1'b1;
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
        send_frame(8'h55, 1'b0, -1);
        repeat (49) hold(1'b0);
        #1;
        check("break_busy",  32'(busy),          32'd1);
        check("break_fe",    32'(fe_cnt - fe0),  32'd1);
        check("break_valid", 32'(vcyc - v0),     32'd0);
        hold(1'b1);
        #1;
        check("break_idle",  32'(busy),          32'd0);
        hold(1'b1);
        send_frame(8'hA5, 1'b1, -1);
        expq.push_back(8'hA5);
        hold(1'b1);
        cmp_rx("after_break");
        check("break_ov", 32'(ov_cnt - ov0), 32'd0);

        // 5: short glitch on an idle line
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; v0 = vcyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        #1;
        check("glitch_busy", 32'(busy), 32'd1);
        repeat (2) hold(1'b1);
        #1;
        check("glitch_idle",  32'(busy),         32'd0);
        check("glitch_valid", 32'(vcyc - v0),    32'd0);
        check("glitch_fe",    32'(fe_cnt - fe0), 32'd0);
        cmp_rx("glitch");

        // 6: reset during data bit 4 while a byte is still pending
        ack = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        hold(1'b1);
        #1;
        check("pre_rst_valid", 32'(valid),    32'd1);
        check("pre_rst_data",  32'(data_out), 32'h5A);
        send_frame(8'hC3, 1'b1, 4);
        repeat (2) hold(1'b1);
        ack = 1'b1;
        base = rxq.size(); expq.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, -1);
        expq.push_back(8'h3C);
        hold(1'b1);
        cmp_rx("post_rst");
        check("post_rst_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        check("pulse_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
